// File: rtl/master_slave_burst_sender.sv
// Burst sender: accepts one signed 32-bit value per handshake and emits BURST_LEN
// arithmetic words (step STEP) with a per-word strobe; optional MASTER_SLAVE_BURST_SENDER_TXCNT_EN adds tx_count.
module master_slave_burst_sender #(
    parameter int unsigned        BURST_LEN = 4,
    parameter logic signed [31:0] STEP      = 32'sd1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] b_in,
    input  logic               b_in_sync,
    output logic               b_in_notify,
    output logic signed [31:0] m_out,
    output logic               m_out_sync,
    output logic signed [31:0] s_out
`ifdef MASTER_SLAVE_BURST_SENDER_TXCNT_EN
    ,
    output logic        [31:0] tx_count
`endif
);

    typedef enum logic {
        SEC_IDLE = 1'b0,
        SEC_EMIT = 1'b1
    } sections_t;

    localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

    sections_t          r_section;
    logic signed [31:0] r_base;
    logic        [7:0]  r_idx;
    logic signed [31:0] r_m_out;
    logic               r_m_out_sync;
    logic signed [31:0] r_s_out;

    sections_t          w_section_nxt;
    logic signed [31:0] w_base_nxt;
    logic        [7:0]  w_idx_nxt;
    logic signed [31:0] w_m_out_nxt;
    logic               w_m_out_sync_nxt;
    logic signed [31:0] w_s_out_nxt;
    logic signed [31:0] w_word;

    // Current burst word; 32-bit product and sum wrap modulo 2^32 by construction.
    assign w_word = r_base + ($signed({24'd0, r_idx}) * STEP);

    assign b_in_notify = (r_section == SEC_IDLE);
    assign m_out       = r_m_out;
    assign m_out_sync  = r_m_out_sync;
    assign s_out       = r_s_out;

    // Next-state and next-output logic for the idle/emit sections.
    always_comb begin
        w_section_nxt    = r_section;
        w_base_nxt       = r_base;
        w_idx_nxt        = r_idx;
        w_m_out_nxt      = r_m_out;
        w_m_out_sync_nxt = 1'b0;
        w_s_out_nxt      = r_s_out;
        case (r_section)
            SEC_IDLE: begin
                if (b_in_sync) begin
                    w_base_nxt    = b_in;
                    w_idx_nxt     = 8'd0;
                    w_section_nxt = SEC_EMIT;
                end else begin
                    w_section_nxt = SEC_IDLE;
                end
            end
            SEC_EMIT: begin
                w_m_out_nxt      = w_word;
                w_m_out_sync_nxt = 1'b1;
                w_s_out_nxt      = w_word;
                w_idx_nxt        = r_idx + 8'd1;
                if (r_idx == LAST_IDX) begin
                    w_section_nxt = SEC_IDLE;
                end else begin
                    w_section_nxt = SEC_EMIT;
                end
            end
            default: begin
                w_section_nxt = SEC_IDLE;
            end
        endcase
    end

    // State and registered-output update; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_section    <= SEC_IDLE;
            r_base       <= 32'sd0;
            r_idx        <= 8'd0;
            r_m_out      <= 32'sd0;
            r_m_out_sync <= 1'b0;
            r_s_out      <= 32'sd0;
        end else begin
            r_section    <= w_section_nxt;
            r_base       <= w_base_nxt;
            r_idx        <= w_idx_nxt;
            r_m_out      <= w_m_out_nxt;
            r_m_out_sync <= w_m_out_sync_nxt;
            r_s_out      <= w_s_out_nxt;
        end
    end

`ifdef MASTER_SLAVE_BURST_SENDER_TXCNT_EN
    logic [31:0] r_tx_count;

    // Counts emitted words, kept in step with the registered strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_count <= 32'd0;
        end else if (w_m_out_sync_nxt) begin
            r_tx_count <= r_tx_count + 32'd1;
        end else begin
            r_tx_count <= r_tx_count;
        end
    end

    assign tx_count = r_tx_count;
`endif

endmodule

// File: tb/tb_master_slave_burst_sender.sv
// Scoreboard bench: three sender instances with different BURST_LEN/STEP, driven with
// directed and random handshakes and compared against a word-list reference model.
module tb_master_slave_burst_sender;

    localparam int NL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] b_in        [NL];
    logic        b_in_sync   [NL];
    logic        b_in_notify [NL];
    logic [31:0] m_out       [NL];
    logic        m_out_sync  [NL];
    logic [31:0] s_out       [NL];
`ifdef MASTER_SLAVE_BURST_SENDER_TXCNT_EN
    logic [31:0] tx_count    [NL];
`endif

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          cnt      [NL];
    logic        exp_sync [NL];
    logic [31:0] exp_q    [NL][$];
    logic [31:0] last     [NL];
    logic [31:0] txc      [NL];

    always #5 clk = ~clk;

    master_slave_burst_sender #(.BURST_LEN(4), .STEP(32'sd1)) u_l0 (
        .clk(clk), .rst(rst), .b_in(b_in[0]), .b_in_sync(b_in_sync[0]),
        .b_in_notify(b_in_notify[0]), .m_out(m_out[0]), .m_out_sync(m_out_sync[0]),
        .s_out(s_out[0])
`ifdef MASTER_SLAVE_BURST_SENDER_TXCNT_EN
        , .tx_count(tx_count[0])
`endif
    );

    master_slave_burst_sender #(.BURST_LEN(4), .STEP(-32'sd3)) u_l1 (
        .clk(clk), .rst(rst), .b_in(b_in[1]), .b_in_sync(b_in_sync[1]),
        .b_in_notify(b_in_notify[1]), .m_out(m_out[1]), .m_out_sync(m_out_sync[1]),
        .s_out(s_out[1])
`ifdef MASTER_SLAVE_BURST_SENDER_TXCNT_EN
        , .tx_count(tx_count[1])
`endif
    );

    master_slave_burst_sender #(.BURST_LEN(1), .STEP(32'sd7)) u_l2 (
        .clk(clk), .rst(rst), .b_in(b_in[2]), .b_in_sync(b_in_sync[2]),
        .b_in_notify(b_in_notify[2]), .m_out(m_out[2]), .m_out_sync(m_out_sync[2]),
        .s_out(s_out[2])
`ifdef MASTER_SLAVE_BURST_SENDER_TXCNT_EN
        , .tx_count(tx_count[2])
`endif
    );

    function automatic int lane_bl(input int l);
        case (l)
            0:       return 4;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int lane_step(input int l);
        case (l)
            0:       return 1;
            1:       return -3;
            default: return 7;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference model: an accepted value becomes a list of BURST_LEN expected words;
    // the block is busy (not ready) for BURST_LEN cycles after the accept edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < NL; l++) begin
                cnt[l]      = 0;
                exp_sync[l] = 1'b0;
                exp_q[l].delete();
            end
        end else begin
            for (int l = 0; l < NL; l++) begin
                exp_sync[l] = (cnt[l] > 0);
                if (cnt[l] == 0 && b_in_sync[l]) begin
                    cnt[l] = lane_bl(l);
                    for (int k = 0; k < lane_bl(l); k++)
                        exp_q[l].push_back(b_in[l] + 32'(k * lane_step(l)));
                end else if (cnt[l] > 0) begin
                    cnt[l] = cnt[l] - 1;
                end
            end
        end
    end

    // Monitor: compare every output of every lane once per cycle, away from the edge.
    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (!rst) begin
                last[l] = 32'd0;
                txc[l]  = 32'd0;
            end else begin
                if (exp_sync[l]) begin
                    if (exp_q[l].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL lane%0d scoreboard_underflow actual=empty required=word", l);
                    end else begin
                        last[l] = exp_q[l].pop_front();
                    end
                    txc[l] = txc[l] + 32'd1;
                end
                chk($sformatf("lane%0d b_in_notify", l), {31'd0, b_in_notify[l]}, {31'd0, cnt[l] == 0});
                chk($sformatf("lane%0d m_out_sync", l), {31'd0, m_out_sync[l]}, {31'd0, exp_sync[l]});
                chk($sformatf("lane%0d m_out", l), m_out[l], last[l]);
                chk($sformatf("lane%0d s_out", l), s_out[l], last[l]);
`ifdef MASTER_SLAVE_BURST_SENDER_TXCNT_EN
                chk($sformatf("lane%0d tx_count", l), tx_count[l], txc[l]);
`endif
            end
        end
    end

    // Hold a value on one lane until it is accepted (bounded wait).
    task automatic offer(input int l, input logic [31:0] v);
        int n;
        @(negedge clk);
        b_in[l]      = v;
        b_in_sync[l] = 1'b1;
        n = 0;
        while (!b_in_notify[l] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL lane%0d offer_timeout actual=notify_low required=accept", l);
        end
        @(negedge clk);
        b_in_sync[l] = 1'b0;
    endtask

    task automatic drive_idle();
        for (int l = 0; l < NL; l++) begin
            b_in_sync[l] = 1'b0;
            b_in[l]      = 32'd0;
        end
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // directed bursts, including negative step and 32-bit wrap
        offer(0, 32'd10);
        offer(1, 32'hFFFF_FFFB);
        offer(2, 32'h1234_5678);
        repeat (8) @(negedge clk);
        chk("dir s_out_after_10", s_out[0], 32'd13);
        chk("dir s_out_after_m5", s_out[1], 32'hFFFF_FFF2);
        chk("dir s_out_len1", s_out[2], 32'h1234_5678);
        offer(0, 32'h7FFF_FFFF);
        repeat (6) @(negedge clk);
        chk("dir s_out_wrap", s_out[0], 32'h8000_0002);

        // valid held high with changing data: only accept-edge values are burst
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                b_in_sync[l] = 1'b1;
                b_in[l]      = $urandom;
            end
        end

        // random handshakes
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                b_in_sync[l] = ($urandom_range(0, 1) == 1);
                b_in[l]      = $urandom;
            end
        end
        @(negedge clk);
        drive_idle();
        repeat (8) @(negedge clk);

        // asynchronous reset during the second word of a burst
        offer(0, 32'hABCD_0000);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst m_out_sync", {31'd0, m_out_sync[0]}, 32'd0);
        chk("arst s_out", s_out[0], 32'd0);
        chk("arst m_out", m_out[0], 32'd0);
`ifdef MASTER_SLAVE_BURST_SENDER_TXCNT_EN
        chk("arst tx_count", tx_count[0], 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        offer(0, 32'h0000_0055);
        repeat (8) @(negedge clk);
        chk("post_rst s_out", s_out[0], 32'h0000_0058);
`ifdef MASTER_SLAVE_BURST_SENDER_TXCNT_EN
        chk("post_rst tx_count", tx_count[0], 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
